// File: rtl/ibus_sram_responder_pkg.sv
// Shared types and constants for the ibus-to-async-SRAM responder.
package ibus_sram_responder_pkg;

  // Width of the wait-state counter; WAIT_CYCLES must fit in it (0..15).
  localparam int CNT_W = 4;

  // Access sequencer states. END states exist only for writes (data hold).
  typedef enum logic [2:0] {
    IDLE,
    LO_ACT,
    LO_END,
    HI_ACT,
    HI_END,
    DONE
  } state_t;

  // Active-low byte enables for one half-word access: reads fetch both
  // bytes, writes enable only the requested lanes.
  function automatic logic [1:0] act_ben(input logic wr, input logic [1:0] be_half);
    return wr ? ~be_half : 2'b00;
  endfunction

endpackage

// File: rtl/ibus_sram_responder_if.sv
// CPU instruction-bus signal bundle between naive_mips and its responder.
//
// Handshake: the master raises read or write (with address, byteenable and
// wrdata) and holds the request until it samples stall low at a clock edge;
// rddata is valid in that same cycle. stall is combinational from the
// request, so it is high in the very cycle a request appears. Dropping the
// request early abandons the transfer at the next half-word boundary.
interface ibus_sram_responder_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic        stall;

  modport master (
    output address, byteenable, read, write, wrdata,
    input  rddata, stall
  );

  modport slave (
    input  address, byteenable, read, write, wrdata,
    output rddata, stall
  );
endinterface

// File: rtl/ibus_sram_responder.sv
// Instruction-bus responder: splits each 32-bit ibus access into two 16-bit
// async-SRAM accesses (low half-word first) with programmable wait states.
module ibus_sram_responder
  import ibus_sram_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ibus_sram_responder_if.slave ibus,
  output logic [ADDR_W-1:0]    emc_addr,
  output logic                 emc_ce_n,
  output logic                 emc_oe_n,
  output logic                 emc_we_n,
  output logic [1:0]           emc_ben,
  output logic [15:0]          emc_dq_o,
  output logic [15:0]          emc_dq_t,
  input  logic [15:0]          emc_dq_i,
  output state_t               state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam int               HA_W     = ADDR_W - 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [HA_W-1:0]  lat_haddr;
  logic [15:0]      lat_data_hi;
  logic [1:0]       lat_be_hi;
  logic             lat_wr;
  logic [31:0]      rddata_q;

  logic             req;
  logic             done;
  logic [HA_W-1:0]  req_haddr;
  logic             unused_addr_bits;

  assign req       = ibus.read | ibus.write;
  assign done      = (state == DONE);
  assign req_haddr = ibus.address[ADDR_W:2];

  // Address bits outside the SRAM word range are deliberately ignored.
  assign unused_addr_bits = ^{ibus.address[31:ADDR_W+1], ibus.address[1:0]};

  // Stall follows the request until the DONE cycle; reset forces IDLE so it
  // simply mirrors the request while rst_n is low.
  assign ibus.stall  = req & ~done;
  assign ibus.rddata = rddata_q;
  assign state_dbg   = state;

  // Access sequencer with registered SRAM strobes and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_haddr   <= '0;
      lat_data_hi <= '0;
      lat_be_hi   <= '0;
      lat_wr      <= 1'b0;
      rddata_q    <= '0;
      emc_addr    <= '0;
      emc_ce_n    <= 1'b1;
      emc_oe_n    <= 1'b1;
      emc_we_n    <= 1'b1;
      emc_ben     <= 2'b11;
      emc_dq_o    <= '0;
      emc_dq_t    <= 16'hFFFF;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Write wins when both read and write are raised.
            lat_haddr   <= req_haddr;
            lat_data_hi <= ibus.wrdata[31:16];
            lat_be_hi   <= ibus.byteenable[3:2];
            lat_wr      <= ibus.write;
            cnt         <= CNT_LOAD;
            if (ibus.write && ibus.byteenable == 4'b0000) begin
              state <= DONE;
            end else if (ibus.write && ibus.byteenable[1:0] == 2'b00) begin
              state    <= HI_ACT;
              emc_addr <= {req_haddr, 1'b1};
              emc_ce_n <= 1'b0;
              emc_we_n <= 1'b0;
              emc_ben  <= act_ben(1'b1, ibus.byteenable[3:2]);
              emc_dq_o <= ibus.wrdata[31:16];
              emc_dq_t <= '0;
            end else begin
              state    <= LO_ACT;
              emc_addr <= {req_haddr, 1'b0};
              emc_ce_n <= 1'b0;
              emc_oe_n <= ibus.write;
              emc_we_n <= ~ibus.write;
              emc_ben  <= act_ben(ibus.write, ibus.byteenable[1:0]);
              if (ibus.write) begin
                emc_dq_o <= ibus.wrdata[15:0];
                emc_dq_t <= '0;
              end
            end
          end
        end

        LO_ACT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= CNT_LOAD;
            if (lat_wr) begin
              // End the write pulse but keep data driven for one hold cycle.
              state    <= LO_END;
              emc_we_n <= 1'b1;
            end else begin
              rddata_q[15:0] <= emc_dq_i;
              if (req) begin
                state    <= HI_ACT;
                emc_addr <= {lat_haddr, 1'b1};
              end else begin
                state    <= IDLE;
                emc_ce_n <= 1'b1;
                emc_oe_n <= 1'b1;
                emc_ben  <= 2'b11;
              end
            end
          end
        end

        LO_END: begin
          if (req && lat_be_hi != 2'b00) begin
            state    <= HI_ACT;
            emc_addr <= {lat_haddr, 1'b1};
            emc_we_n <= 1'b0;
            emc_ben  <= act_ben(1'b1, lat_be_hi);
            emc_dq_o <= lat_data_hi;
          end else begin
            state    <= req ? DONE : IDLE;
            emc_ce_n <= 1'b1;
            emc_ben  <= 2'b11;
            emc_dq_t <= 16'hFFFF;
          end
        end

        HI_ACT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= CNT_LOAD;
            if (lat_wr) begin
              state    <= HI_END;
              emc_we_n <= 1'b1;
            end else begin
              rddata_q[31:16] <= emc_dq_i;
              state           <= req ? DONE : IDLE;
              emc_ce_n        <= 1'b1;
              emc_oe_n        <= 1'b1;
              emc_ben         <= 2'b11;
            end
          end
        end

        HI_END: begin
          state    <= req ? DONE : IDLE;
          emc_ce_n <= 1'b1;
          emc_ben  <= 2'b11;
          emc_dq_t <= 16'hFFFF;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench: two responders (WAIT_CYCLES=1 and 0) each on its own
// behavioural async-SRAM model.
module tb_ibus_sram_responder;
  import ibus_sram_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and SRAM models ----------------
  ibus_sram_responder_if if_a ();
  ibus_sram_responder_if if_b ();

  logic [17:0] a_addr, b_addr;
  logic        a_ce_n, a_oe_n, a_we_n, b_ce_n, b_oe_n, b_we_n;
  logic [1:0]  a_ben, b_ben;
  logic [15:0] a_dq_o, a_dq_t, a_dq_i, b_dq_o, b_dq_t, b_dq_i;
  state_t      a_dbg, b_dbg;

  ibus_sram_responder #(.WAIT_CYCLES(1), .ADDR_W(18)) dut_a (
    .clk(clk), .rst_n(rst_n), .ibus(if_a.slave),
    .emc_addr(a_addr), .emc_ce_n(a_ce_n), .emc_oe_n(a_oe_n), .emc_we_n(a_we_n),
    .emc_ben(a_ben), .emc_dq_o(a_dq_o), .emc_dq_t(a_dq_t), .emc_dq_i(a_dq_i),
    .state_dbg(a_dbg)
  );

  ibus_sram_responder #(.WAIT_CYCLES(0), .ADDR_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .ibus(if_b.slave),
    .emc_addr(b_addr), .emc_ce_n(b_ce_n), .emc_oe_n(b_oe_n), .emc_we_n(b_we_n),
    .emc_ben(b_ben), .emc_dq_o(b_dq_o), .emc_dq_t(b_dq_t), .emc_dq_i(b_dq_i),
    .state_dbg(b_dbg)
  );

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pl_we;
  logic        pl_sel;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  assign a_dq_i = (!a_ce_n && !a_oe_n) ? mem_a[a_addr[7:0]] : 16'h0000;
  assign b_dq_i = (!b_ce_n && !b_oe_n) ? mem_b[b_addr[7:0]] : 16'h0000;

  // SRAM write model plus bench preload port.
  always @(posedge clk) begin
    if (pl_we) begin
      if (pl_sel) mem_b[pl_addr] <= pl_data;
      else        mem_a[pl_addr] <= pl_data;
    end
    if (!a_ce_n && !a_we_n && a_dq_t == 16'h0000) begin
      if (!a_ben[0]) mem_a[a_addr[7:0]][7:0]  <= a_dq_o[7:0];
      if (!a_ben[1]) mem_a[a_addr[7:0]][15:8] <= a_dq_o[15:8];
    end
    if (!b_ce_n && !b_we_n && b_dq_t == 16'h0000) begin
      if (!b_ben[0]) mem_b[b_addr[7:0]][7:0]  <= b_dq_o[7:0];
      if (!b_ben[1]) mem_b[b_addr[7:0]][15:8] <= b_dq_o[15:8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  int          stall_cyc, we_low, hold, edges;
  logic [17:0] first_addr, last_addr;
  logic [1:0]  last_ben;
  logic [31:0] rdata;

  function automatic logic cur_stall(input bit sel);
    return sel ? if_b.stall : if_a.stall;
  endfunction

  task automatic preload(input bit sel, input logic [7:0] addr, input logic [15:0] data);
    pl_we = 1'b1; pl_sel = sel; pl_addr = addr; pl_data = data;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic bus_idle();
    if_a.read = 1'b0; if_a.write = 1'b0;
    if_b.read = 1'b0; if_b.write = 1'b0;
    @(posedge clk); #1;
  endtask

  // Presents a request and waits (bounded) until stall drops. Strobe
  // statistics are collected from DUT A.
  task automatic do_req(input bit sel, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
    bit seen;
    if (sel) begin
      if_b.read = rd; if_b.write = wr; if_b.address = addr; if_b.byteenable = be; if_b.wrdata = data;
    end else begin
      if_a.read = rd; if_a.write = wr; if_a.address = addr; if_a.byteenable = be; if_a.wrdata = data;
    end
    #1;
    stall_cyc = cur_stall(sel) ? 1 : 0;
    we_low = 0; hold = 0; edges = 0; seen = 1'b0;
    first_addr = '1; last_addr = '1; last_ben = 2'b11;
    do begin
      @(posedge clk); #1;
      edges++;
      if (cur_stall(sel)) stall_cyc++;
      if (!a_ce_n) begin
        if (!seen) first_addr = a_addr;
        seen = 1'b1;
        last_addr = a_addr;
        last_ben = a_ben;
      end
      if (!a_we_n) we_low++;
      if (!a_ce_n && a_we_n && a_dq_t == 16'h0000) hold++;
    end while (cur_stall(sel) && edges < 50);
    rdata = sel ? if_b.rddata : if_a.rddata;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int hi_seen;
    rst_n = 1'b0;
    pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    if_a.read = 0; if_a.write = 0; if_a.address = '0; if_a.byteenable = '0; if_a.wrdata = '0;
    if_b.read = 0; if_b.write = 0; if_b.address = '0; if_b.byteenable = '0; if_b.wrdata = '0;

    preload(0, 8'd8, 16'h5678);
    preload(0, 8'd9, 16'h1234);
    preload(0, 8'd16, 16'h0000);
    preload(0, 8'd17, 16'h0000);
    preload(1, 8'd0, 16'hA0A0);
    preload(1, 8'd1, 16'hB1B1);
    preload(1, 8'd2, 16'hC2C2);
    preload(1, 8'd3, 16'hD3D3);

    // Reset state
    check("rst_ce_n", 32'(a_ce_n), 32'd1);
    check("rst_oe_n", 32'(a_oe_n), 32'd1);
    check("rst_we_n", 32'(a_we_n), 32'd1);
    check("rst_ben", 32'(a_ben), 32'h3);
    check("rst_dq_t", 32'(a_dq_t), 32'hFFFF);
    check("rst_dq_o", 32'(a_dq_o), 32'h0);
    check("rst_addr", 32'(a_addr), 32'h0);
    check("rst_rddata", if_a.rddata, 32'h0);
    check("rst_stall", 32'(if_a.stall), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: read W=1 @0x80000010
    do_req(0, 1, 0, 32'h8000_0010, 4'hF, 32'h0);
    check("t1_stall_cycles", 32'(stall_cyc), 32'd5);
    check("t1_rddata", rdata, 32'h1234_5678);
    check("t1_addr_lo", 32'(first_addr), 32'd8);
    check("t1_addr_hi", 32'(last_addr), 32'd9);
    bus_idle();

    // 2: full write 0xDEADBEEF @0x20
    do_req(0, 0, 1, 32'h0000_0020, 4'b1111, 32'hDEAD_BEEF);
    check("t2_stall_cycles", 32'(stall_cyc), 32'd7);
    check("t2_we_low_cycles", 32'(we_low), 32'd4);
    check("t2_data_hold_cycles", 32'(hold), 32'd2);
    check("t2_dq_t_released", 32'(a_dq_t), 32'hFFFF);
    check("t2_rddata_kept", rdata, 32'h1234_5678);
    bus_idle();
    check("t2_sram16", 32'(mem_a[16]), 32'hBEEF);
    check("t2_sram17", 32'(mem_a[17]), 32'hDEAD);

    // 3: byte write, lane 2 only -> hi half low byte
    do_req(0, 0, 1, 32'h0000_0020, 4'b0100, 32'hAABB_CCDD);
    check("t3_stall_cycles", 32'(stall_cyc), 32'd4);
    check("t3_ben", 32'(last_ben), 32'h2);
    check("t3_first_addr", 32'(first_addr), 32'd17);
    check("t3_we_low_cycles", 32'(we_low), 32'd2);
    bus_idle();
    check("t3_sram16", 32'(mem_a[16]), 32'hBEEF);
    check("t3_sram17", 32'(mem_a[17]), 32'hDEBB);

    // 4: back-to-back reads on W=0 responder
    do_req(1, 1, 0, 32'h0000_0000, 4'hF, 32'h0);
    check("t4_rd0_stall", 32'(stall_cyc), 32'd3);
    check("t4_rd0_data", rdata, 32'hB1B1_A0A0);
    do_req(1, 1, 0, 32'h0000_0004, 4'hF, 32'h0);
    check("t4_rd1_stall", 32'(stall_cyc), 32'd3);
    check("t4_rd1_data", rdata, 32'hD3D3_C2C2);
    check("t4_state_done", 32'(b_dbg), 32'(DONE));
    bus_idle();

    // 5: async reset during HI_ACT of a write
    preload(0, 8'd32, 16'h0000);
    preload(0, 8'd33, 16'h3333);
    if_a.write = 1'b1; if_a.address = 32'h40; if_a.byteenable = 4'hF; if_a.wrdata = 32'h9999_7777;
    edges = 0;
    while (a_dbg !== HI_ACT && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("t5_reached_hi_act", 32'(a_dbg), 32'(HI_ACT));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ce_n", 32'(a_ce_n), 32'd1);
    check("t5_rst_we_n", 32'(a_we_n), 32'd1);
    check("t5_rst_dq_t", 32'(a_dq_t), 32'hFFFF);
    check("t5_rst_stall", 32'(if_a.stall), 32'd1);
    check("t5_rst_rddata", if_a.rddata, 32'h0);
    check("t5_rst_state", 32'(a_dbg), 32'(IDLE));
    if_a.write = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(0, 1, 0, 32'h0000_0040, 4'hF, 32'h0);
    check("t5_read_back", rdata, 32'h3333_7777);
    bus_idle();

    // 6: read dropped during LO_ACT
    preload(0, 8'd48, 16'h4848);
    preload(0, 8'd49, 16'h4949);
    if_a.read = 1'b1; if_a.address = 32'h60;
    @(posedge clk); #1;
    check("t6_in_lo_act", 32'(a_dbg), 32'(LO_ACT));
    if_a.read = 1'b0;
    hi_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (!a_ce_n && a_addr == 18'd49) hi_seen++;
    end
    check("t6_no_hi_access", 32'(hi_seen), 32'd0);
    check("t6_state_idle", 32'(a_dbg), 32'(IDLE));
    check("t6_strobes_off", 32'(a_ce_n), 32'd1);
    do_req(0, 1, 0, 32'h0000_0060, 4'hF, 32'h0);
    check("t6_next_stall", 32'(stall_cyc), 32'd5);
    check("t6_next_data", rdata, 32'h4949_4848);
    bus_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
